// File: rtl/click_decoder_if.sv
`default_nettype none
// ============================================================================
// Module      : click_decoder_if
// Description : Press-pulse input and click-event output bundle of the
//               click decoder.
// Revision    : 1.0 - initial release
// ============================================================================
interface click_decoder_if;
    logic       en_i;
    logic       pulse_i;
    logic       evt_single_o;
    logic       evt_double_o;
    logic       evt_triple_o;
    logic [1:0] evt_count_o;
    logic       busy_o;

    // Producer of presses / consumer of click events.
    modport master (
        output en_i,
        output pulse_i,
        input  evt_single_o,
        input  evt_double_o,
        input  evt_triple_o,
        input  evt_count_o,
        input  busy_o
    );

    // The decoder itself.
    modport slave (
        input  en_i,
        input  pulse_i,
        output evt_single_o,
        output evt_double_o,
        output evt_triple_o,
        output evt_count_o,
        output busy_o
    );
endinterface
`default_nettype wire

// File: rtl/click_decoder.sv
`default_nettype none
// ============================================================================
// Module      : click_decoder
// Description : Classifies debounced press pulses into single, double or
//               triple clicks using an inter-press gap timer.
// Revision    : 1.0 - initial release
// ============================================================================
module click_decoder #(
    parameter int WIN_W   = 24,
    parameter int WIN_CYC = 15000000
) (
    input  wire              clk_i,
    input  wire              rst_ni,
    click_decoder_if.slave   bus
);

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_WAIT = 1'b1
    } state_t;

    // Last timer value of an open gap; reaching it without a press closes it.
    localparam logic [WIN_W-1:0] c_timer_last = WIN_W'(WIN_CYC - 1);

    state_t           r_state;
    logic [1:0]       r_cnt;
    logic [WIN_W-1:0] r_timer;
    logic             r_evt_single;
    logic             r_evt_double;
    logic             r_evt_triple;
    logic [1:0]       r_evt_count;
    logic             r_busy;

    state_t           w_state;
    logic [1:0]       w_cnt;
    logic [WIN_W-1:0] w_timer;
    logic             w_evt_single;
    logic             w_evt_double;
    logic             w_evt_triple;
    logic [1:0]       w_evt_count;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state      <= ST_IDLE;
            r_cnt        <= 2'd0;
            r_timer      <= '0;
            r_evt_single <= 1'b0;
            r_evt_double <= 1'b0;
            r_evt_triple <= 1'b0;
            r_evt_count  <= 2'd0;
            r_busy       <= 1'b0;
        end else begin
            r_state      <= w_state;
            r_cnt        <= w_cnt;
            r_timer      <= w_timer;
            r_evt_single <= w_evt_single;
            r_evt_double <= w_evt_double;
            r_evt_triple <= w_evt_triple;
            r_evt_count  <= w_evt_count;
            r_busy       <= (w_state == ST_WAIT);
        end
    end

    always_comb begin
        w_state      = r_state;
        w_cnt        = r_cnt;
        w_timer      = r_timer;
        w_evt_single = 1'b0;
        w_evt_double = 1'b0;
        w_evt_triple = 1'b0;
        w_evt_count  = 2'd0;

        case (r_state)
            ST_IDLE: begin
                if (bus.pulse_i && bus.en_i) begin
                    w_state = ST_WAIT;
                    w_cnt   = 2'd1;
                    w_timer = '0;
                end
            end

            ST_WAIT: begin
                if (!bus.en_i) begin
                    w_state = ST_IDLE;
                    w_cnt   = 2'd0;
                    w_timer = '0;
                end else if (bus.pulse_i && (r_cnt == 2'd2)) begin
                    w_state      = ST_IDLE;
                    w_cnt        = 2'd0;
                    w_timer      = '0;
                    w_evt_triple = 1'b1;
                    w_evt_count  = 2'd3;
                end else if (bus.pulse_i) begin
                    // A press on the expiry edge is counted and restarts the gap.
                    w_cnt   = r_cnt + 2'd1;
                    w_timer = '0;
                end else if (r_timer == c_timer_last) begin
                    w_state      = ST_IDLE;
                    w_cnt        = 2'd0;
                    w_timer      = '0;
                    w_evt_single = (r_cnt == 2'd1);
                    w_evt_double = (r_cnt == 2'd2);
                    w_evt_count  = r_cnt;
                end else begin
                    w_timer = r_timer + WIN_W'(1);
                end
            end

            default: begin
                w_state = ST_IDLE;
                w_cnt   = 2'd0;
                w_timer = '0;
            end
        endcase
    end

    assign bus.evt_single_o = r_evt_single;
    assign bus.evt_double_o = r_evt_double;
    assign bus.evt_triple_o = r_evt_triple;
    assign bus.evt_count_o  = r_evt_count;
    assign bus.busy_o       = r_busy;

endmodule
`default_nettype wire

// File: tb/tb_click_decoder.sv
`default_nettype none
// ============================================================================
// Module      : tb_click_decoder
// Description : Self-checking bench for click_decoder (WIN_CYC=10, WIN_W=4).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_click_decoder;

    localparam int WIN_W   = 4;
    localparam int WIN_CYC = 10;

    logic clk_i  = 1'b0;
    logic rst_ni = 1'b0;

    click_decoder_if dif ();

    click_decoder #(
        .WIN_W   (WIN_W),
        .WIN_CYC (WIN_CYC)
    ) dut (
        .clk_i  (clk_i),
        .rst_ni (rst_ni),
        .bus    (dif)
    );

    always #5 clk_i = ~clk_i;

    int n_vec  = 0;
    int n_miss = 0;

    // Reference model: presses in the open sequence and the cycle stamp of
    // the last counted press; a sequence closes when the gap reaches WIN_CYC.
    int m_presses = 0;
    int m_last    = 0;
    int m_now     = 0;

    int e_single, e_double, e_triple, e_count, e_busy;

    task automatic check(input string tag, input int obs, input int exp);
        n_vec++;
        if (obs != exp) begin
            n_miss++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // Drive one cycle of inputs, predict, clock, then compare.
    task automatic cycle(input logic p, input logic e);
        dif.pulse_i = p;
        dif.en_i    = e;
        e_single = 0; e_double = 0; e_triple = 0; e_count = 0;
        if (m_presses == 0) begin
            if (p && e) begin
                m_presses = 1;
                m_last    = m_now;
            end
        end else if (!e) begin
            m_presses = 0;
        end else if (p) begin
            if (m_presses == 2) begin
                e_triple  = 1;
                e_count   = 3;
                m_presses = 0;
            end else begin
                m_presses++;
                m_last = m_now;
            end
        end else if (m_now - m_last == WIN_CYC) begin
            e_single  = (m_presses == 1);
            e_double  = (m_presses == 2);
            e_count   = m_presses;
            m_presses = 0;
        end
        e_busy = (m_presses != 0);
        m_now++;

        @(posedge clk_i);
        #1;
        check("single", dif.evt_single_o, e_single);
        check("double", dif.evt_double_o, e_double);
        check("triple", dif.evt_triple_o, e_triple);
        check("count",  dif.evt_count_o,  e_count);
        check("busy",   dif.busy_o,       e_busy);
    endtask

    // Async reset asserted mid-cycle; outputs must clear without a clock edge.
    task automatic async_reset();
        dif.pulse_i = 1'b0;
        #2;
        rst_ni = 1'b0;
        #1;
        check("rst_single", dif.evt_single_o, 0);
        check("rst_double", dif.evt_double_o, 0);
        check("rst_triple", dif.evt_triple_o, 0);
        check("rst_count",  dif.evt_count_o,  0);
        check("rst_busy",   dif.busy_o,       0);
        @(posedge clk_i);
        #1;
        rst_ni    = 1'b1;
        m_presses = 0;
    endtask

    // Pulses at the cycles set in mask; first strobe cycle/kind and the
    // number of busy cycles are compared with fixed expectations.
    task automatic directed(input string tag, input logic [31:0] mask,
                            input int exp_cyc, input int exp_kind, input int exp_busy);
        int first_c = -1;
        int kind    = 0;
        int busy_n  = 0;
        for (int c = 0; c < 32; c++) begin
            cycle(mask[c], 1'b1);
            if (dif.busy_o) busy_n++;
            if (first_c < 0 && (dif.evt_single_o || dif.evt_double_o || dif.evt_triple_o)) begin
                first_c = c + 1;
                kind    = dif.evt_count_o;
            end
        end
        check({tag, "_cycle"}, first_c, exp_cyc);
        check({tag, "_kind"},  kind,    exp_kind);
        check({tag, "_busy"},  busy_n,  exp_busy);
    endtask

    initial begin
        logic prev_p;
        int   strobes;

        dif.pulse_i = 1'b0;
        dif.en_i    = 1'b0;
        rst_ni      = 1'b0;
        repeat (3) @(posedge clk_i);
        #1;
        check("reset_single", dif.evt_single_o, 0);
        check("reset_double", dif.evt_double_o, 0);
        check("reset_triple", dif.evt_triple_o, 0);
        check("reset_count",  dif.evt_count_o,  0);
        check("reset_busy",   dif.busy_o,       0);
        rst_ni = 1'b1;
        repeat (3) cycle(1'b0, 1'b1);

        directed("single",   32'h0000_0001, 11, 1, 10);
        directed("double",   32'h0000_0021, 16, 2, 15);
        directed("triple",   32'h0000_00C9,  7, 3, 16);
        directed("boundary", 32'h0000_0401, 21, 2, 20);
        directed("late",     32'h0000_0801, 11, 1, 20);

        // Enable dropped mid-sequence discards it.
        strobes = 0;
        for (int c = 0; c < 25; c++) begin
            cycle(c == 0, c != 4);
            strobes += dif.evt_single_o + dif.evt_double_o + dif.evt_triple_o;
            if (c == 4) check("en_abort_busy", dif.busy_o, 0);
        end
        check("en_abort_evts", strobes, 0);

        // Pulses ignored while disabled in IDLE.
        for (int c = 0; c < 15; c++) cycle(c % 3 == 0, 1'b0);

        // Reset while a single strobe is high, then no event after release.
        cycle(1'b1, 1'b1);
        repeat (10) cycle(1'b0, 1'b1);
        check("pre_rst_strobe", dif.evt_single_o, 1);
        async_reset();
        strobes = 0;
        for (int c = 0; c < 15; c++) begin
            cycle(1'b0, 1'b1);
            strobes += dif.evt_single_o + dif.evt_double_o + dif.evt_triple_o;
        end
        check("post_rst_evts", strobes, 0);

        // Randomized traffic with varying press density, enable drops and resets.
        prev_p = 1'b0;
        for (int i = 0; i < 4000; i++) begin
            int   dens;
            logic p;
            logic e;
            dens = (i / 500) % 4 + 2;
            p = !prev_p && ($urandom_range(0, dens) == 0);
            e = ($urandom_range(0, 40) != 0);
            prev_p = p;
            cycle(p, e);
            if ($urandom_range(0, 300) == 0) begin
                async_reset();
                prev_p = 1'b0;
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
`default_nettype wire
